// File: rtl/hog_frame_ctrl.sv
// Frame supervisor for the HOG pipeline: tracks vsync-delimited frames, checks pixel
// counts against the image size, reacts to FIFO alarms and drives the datapath flush.
module hog_frame_ctrl #(
  parameter int IMG_WIDTH    = 1280,
  parameter int IMG_HEIGHT   = 720,
  parameter int FLUSH_CYCLES = 16
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic        vsync,
  input  logic        de_pix,
  input  logic        de_hog,
  input  logic [3:0]  alarms,
  input  logic        clr_sticky,
  output logic        pipe_reset,
  output logic        frame_done,
  output logic        frame_err,
  output logic [1:0]  err_code,
  output logic [20:0] pixel_count_last,
  output logic [23:0] feature_count_last,
  output logic [3:0]  alarm_sticky,
  output logic [1:0]  state_out
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, CHECK = 2'd2, FLUSH = 2'd3} state_t;

  localparam logic [20:0] EXP_PIX    = 21'(IMG_WIDTH * IMG_HEIGHT);
  localparam logic [7:0]  FLUSH_LAST = 8'(FLUSH_CYCLES - 1);

  state_t      state_q, state_d;
  logic        vsync_q;
  logic [20:0] pix_q, pix_d, pix_last_q, pix_last_d;
  logic [23:0] feat_q, feat_d, feat_last_q, feat_last_d;
  logic [7:0]  flush_cnt_q, flush_cnt_d;
  logic        done_q, done_d, err_q, err_d, pipe_reset_q;
  logic [1:0]  err_code_q, err_code_d;
  logic [3:0]  sticky_q, sticky_d;
  logic        vs_edge;
  logic [20:0] pix_sat;
  logic [23:0] feat_sat;

  assign vs_edge  = vsync & ~vsync_q;
  assign pix_sat  = (pix_q == 21'h1FFFFF) ? pix_q : pix_q + 21'd1;
  assign feat_sat = (feat_q == 24'hFFFFFF) ? feat_q : feat_q + 24'd1;

  always_comb begin
    state_d     = state_q;
    pix_d       = pix_q;
    feat_d      = feat_q;
    pix_last_d  = pix_last_q;
    feat_last_d = feat_last_q;
    flush_cnt_d = flush_cnt_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    err_code_d  = err_code_q;
    case (state_q)
      IDLE: begin
        pix_d  = 21'd0;
        feat_d = 24'd0;
        if (vs_edge) state_d = RUN;
        else         state_d = IDLE;
      end
      RUN, CHECK: begin
        if (de_pix) pix_d = pix_sat;
        else        pix_d = pix_q;
        if (de_hog) feat_d = feat_sat;
        else        feat_d = feat_q;
        // Alarms win over both the frame boundary and the count verdict.
        if (|alarms) begin
          state_d     = FLUSH;
          err_d       = 1'b1;
          err_code_d  = 2'd3;
          flush_cnt_d = 8'd0;
        end else if (state_q == CHECK) begin
          if (pix_last_q == EXP_PIX) begin
            state_d    = RUN;
            done_d     = 1'b1;
            err_code_d = 2'd0;
          end else begin
            state_d     = FLUSH;
            err_d       = 1'b1;
            err_code_d  = (pix_last_q < EXP_PIX) ? 2'd1 : 2'd2;
            flush_cnt_d = 8'd0;
          end
        end else if (vs_edge) begin
          state_d     = CHECK;
          pix_last_d  = pix_q;
          feat_last_d = feat_q;
          pix_d       = 21'd0;
          feat_d      = 24'd0;
        end else begin
          state_d = RUN;
        end
      end
      FLUSH: begin
        pix_d  = 21'd0;
        feat_d = 24'd0;
        if (flush_cnt_q == FLUSH_LAST) begin
          state_d = IDLE;
        end else begin
          flush_cnt_d = flush_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // A clear coincident with a new alarm keeps the new alarm.
  always_comb begin
    if (clr_sticky) sticky_d = alarms;
    else            sticky_d = sticky_q | alarms;
  end

  // vsync_q resets high so a vsync already high at reset release is not an edge.
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      vsync_q      <= 1'b1;
      pix_q        <= 21'd0;
      feat_q       <= 24'd0;
      pix_last_q   <= 21'd0;
      feat_last_q  <= 24'd0;
      flush_cnt_q  <= 8'd0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      err_code_q   <= 2'd0;
      sticky_q     <= 4'd0;
      pipe_reset_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      vsync_q      <= vsync;
      pix_q        <= pix_d;
      feat_q       <= feat_d;
      pix_last_q   <= pix_last_d;
      feat_last_q  <= feat_last_d;
      flush_cnt_q  <= flush_cnt_d;
      done_q       <= done_d;
      err_q        <= err_d;
      err_code_q   <= err_code_d;
      sticky_q     <= sticky_d;
      pipe_reset_q <= (state_d == FLUSH);
    end
  end

  assign pipe_reset         = pipe_reset_q;
  assign frame_done         = done_q;
  assign frame_err          = err_q;
  assign err_code           = err_code_q;
  assign pixel_count_last   = pix_last_q;
  assign feature_count_last = feat_last_q;
  assign alarm_sticky       = sticky_q;
  assign state_out          = state_q;

endmodule

// File: tb/tb_hog_frame_ctrl.sv
// Directed bench for hog_frame_ctrl on a reduced 32x8 image (256 pixels per frame).
module tb_hog_frame_ctrl;

  logic        pclk = 1'b0;
  logic        reset, vsync, de_pix, de_hog, clr_sticky;
  logic [3:0]  alarms;
  logic        pipe_reset, frame_done, frame_err;
  logic [1:0]  err_code, state_out;
  logic [20:0] pixel_count_last;
  logic [23:0] feature_count_last;
  logic [3:0]  alarm_sticky;

  int total = 0;
  int bad   = 0;

  hog_frame_ctrl #(.IMG_WIDTH(32), .IMG_HEIGHT(8), .FLUSH_CYCLES(16)) dut (
    .pclk(pclk), .reset(reset), .vsync(vsync), .de_pix(de_pix), .de_hog(de_hog),
    .alarms(alarms), .clr_sticky(clr_sticky), .pipe_reset(pipe_reset),
    .frame_done(frame_done), .frame_err(frame_err), .err_code(err_code),
    .pixel_count_last(pixel_count_last), .feature_count_last(feature_count_last),
    .alarm_sticky(alarm_sticky), .state_out(state_out)
  );

  always #5 pclk = ~pclk;

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int i;
    for (i = 0; i < 100; i++) begin
      if (state_out == 2'd0) break;
      tick();
    end
    total++;
    if (state_out !== 2'd0) begin
      bad++;
      $display("FAIL %s: timeout waiting for IDLE, state=%0d want 0", name, state_out);
    end
  endtask

  task automatic test_reset();
    #2;
    total++;
    if ({state_out, pipe_reset, frame_done, frame_err, err_code, alarm_sticky} !== 11'd0 ||
        pixel_count_last !== 21'd0 || feature_count_last !== 24'd0) begin
      bad++;
      $display("FAIL reset_state: got st=%0d pr=%0b fd=%0b fe=%0b ec=%0d as=%b want all 0",
               state_out, pipe_reset, frame_done, frame_err, err_code, alarm_sticky);
    end
    tick(); tick();
    reset = 1'b0;
    tick();
    total++;
    if (state_out !== 2'd0) begin
      bad++;
      $display("FAIL idle_after_reset: got %0d want 0", state_out);
    end
  endtask

  task automatic test_good_frame();
    vsync = 1'b1; tick(); vsync = 1'b0;
    total++;
    if (state_out !== 2'd1) begin
      bad++; $display("FAIL start_run: state=%0d want 1", state_out);
    end
    de_pix = 1'b1; repeat (256) tick(); de_pix = 1'b0;
    vsync = 1'b1; tick(); vsync = 1'b0;
    total++;
    if (state_out !== 2'd2 || pixel_count_last !== 21'd256) begin
      bad++; $display("FAIL good_check: state=%0d cnt=%0d want 2/256", state_out, pixel_count_last);
    end
    tick();
    total++;
    if ({state_out, frame_done, frame_err, err_code} !== {2'd1, 1'b1, 1'b0, 2'd0}) begin
      bad++;
      $display("FAIL good_done: st=%0d fd=%0b fe=%0b ec=%0d want 1/1/0/0",
               state_out, frame_done, frame_err, err_code);
    end
    tick();
    total++;
    if (frame_done !== 1'b0) begin
      bad++; $display("FAIL done_pulse_width: fd=%0b want 0", frame_done);
    end
  endtask

  task automatic test_short_frame();
    int n;
    de_pix = 1'b1; repeat (255) tick(); de_pix = 1'b0;
    vsync = 1'b1; tick(); vsync = 1'b0;
    tick();
    total++;
    if ({state_out, frame_done, frame_err, err_code, pipe_reset} !== {2'd3, 1'b0, 1'b1, 2'd1, 1'b1}) begin
      bad++;
      $display("FAIL short_err: st=%0d fd=%0b fe=%0b ec=%0d pr=%0b want 3/0/1/1/1",
               state_out, frame_done, frame_err, err_code, pipe_reset);
    end
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (!pipe_reset) break;
      n++;
      if (n == 5) vsync = 1'b1;
      if (n == 8) vsync = 1'b0;
      tick();
    end
    vsync = 1'b0;
    total++;
    if (n !== 16) begin
      bad++; $display("FAIL flush_len: got %0d cycles want 16", n);
    end
    total++;
    if (state_out !== 2'd0 || err_code !== 2'd1) begin
      bad++; $display("FAIL flush_to_idle: st=%0d ec=%0d want 0/1", state_out, err_code);
    end
    tick();
    total++;
    if (state_out !== 2'd0) begin
      bad++; $display("FAIL flush_vs_ignored: st=%0d want 0", state_out);
    end
    vsync = 1'b1; tick(); vsync = 1'b0;
    total++;
    if (state_out !== 2'd1) begin
      bad++; $display("FAIL rerun_after_flush: st=%0d want 1", state_out);
    end
  endtask

  task automatic test_long_frame();
    de_pix = 1'b1; repeat (257) tick(); de_pix = 1'b0;
    vsync = 1'b1; tick(); vsync = 1'b0;
    total++;
    if (pixel_count_last !== 21'd257) begin
      bad++; $display("FAIL long_count: got %0d want 257", pixel_count_last);
    end
    tick();
    total++;
    if ({state_out, frame_err, err_code} !== {2'd3, 1'b1, 2'd2}) begin
      bad++; $display("FAIL long_err: st=%0d fe=%0b ec=%0d want 3/1/2", state_out, frame_err, err_code);
    end
    wait_idle("long_flush");
  endtask

  task automatic test_alarm_and_sticky();
    vsync = 1'b1; tick(); vsync = 1'b0;
    de_pix = 1'b1; repeat (10) tick(); de_pix = 1'b0;
    alarms = 4'b0100; vsync = 1'b1;
    tick();
    alarms = 4'b0000; vsync = 1'b0;
    total++;
    if ({state_out, frame_done, frame_err, err_code, alarm_sticky} !==
        {2'd3, 1'b0, 1'b1, 2'd3, 4'b0100}) begin
      bad++;
      $display("FAIL alarm_abort: st=%0d fd=%0b fe=%0b ec=%0d as=%b want 3/0/1/3/0100",
               state_out, frame_done, frame_err, err_code, alarm_sticky);
    end
    tick();
    total++;
    if (frame_err !== 1'b0 || frame_done !== 1'b0 || state_out !== 2'd3) begin
      bad++; $display("FAIL alarm_pulse: fe=%0b fd=%0b st=%0d want 0/0/3", frame_err, frame_done, state_out);
    end
    alarms = 4'b0001; tick(); alarms = 4'b0000;
    total++;
    if (alarm_sticky !== 4'b0101) begin
      bad++; $display("FAIL sticky_or: got %b want 0101", alarm_sticky);
    end
    clr_sticky = 1'b1; alarms = 4'b1000; tick();
    clr_sticky = 1'b0; alarms = 4'b0000;
    total++;
    if (alarm_sticky !== 4'b1000) begin
      bad++; $display("FAIL sticky_clr_set: got %b want 1000", alarm_sticky);
    end
    clr_sticky = 1'b1; tick(); clr_sticky = 1'b0;
    total++;
    if (alarm_sticky !== 4'b0000) begin
      bad++; $display("FAIL sticky_clr: got %b want 0000", alarm_sticky);
    end
    wait_idle("alarm_flush");
  endtask

  task automatic test_features();
    vsync = 1'b1; tick(); vsync = 1'b0;
    de_hog = 1'b1; de_pix = 1'b1;
    for (int i = 0; i < 3780; i++) begin
      if (i == 256) de_pix = 1'b0;
      tick();
    end
    de_hog = 1'b0; de_pix = 1'b0;
    vsync = 1'b1; tick(); vsync = 1'b0;
    total++;
    if (state_out !== 2'd2 || feature_count_last !== 24'd3780 || pixel_count_last !== 21'd256) begin
      bad++;
      $display("FAIL feature_count: st=%0d feat=%0d pix=%0d want 2/3780/256",
               state_out, feature_count_last, pixel_count_last);
    end
    tick();
    total++;
    if (frame_done !== 1'b1 || state_out !== 2'd1 || err_code !== 2'd0) begin
      bad++; $display("FAIL feature_done: fd=%0b st=%0d ec=%0d want 1/1/0", frame_done, state_out, err_code);
    end
  endtask

  task automatic test_reset_in_flush();
    de_pix = 1'b1; repeat (100) tick(); de_pix = 1'b0;
    vsync = 1'b1; tick(); vsync = 1'b0;
    tick();
    repeat (5) tick();
    total++;
    if (pipe_reset !== 1'b1 || state_out !== 2'd3) begin
      bad++; $display("FAIL pre_reset_flush: pr=%0b st=%0d want 1/3", pipe_reset, state_out);
    end
    reset = 1'b1; vsync = 1'b1;
    #1;
    total++;
    if ({state_out, pipe_reset, frame_done, frame_err, err_code, alarm_sticky} !== 11'd0 ||
        pixel_count_last !== 21'd0 || feature_count_last !== 24'd0) begin
      bad++;
      $display("FAIL async_reset: st=%0d pr=%0b fd=%0b fe=%0b ec=%0d as=%b pix=%0d feat=%0d want 0",
               state_out, pipe_reset, frame_done, frame_err, err_code, alarm_sticky,
               pixel_count_last, feature_count_last);
    end
    tick(); tick();
    reset = 1'b0;
    tick();
    total++;
    if (state_out !== 2'd0) begin
      bad++; $display("FAIL vs_at_release: st=%0d want 0", state_out);
    end
    vsync = 1'b0; tick();
    vsync = 1'b1; tick(); vsync = 1'b0;
    total++;
    if (state_out !== 2'd1) begin
      bad++; $display("FAIL run_after_reset: st=%0d want 1", state_out);
    end
  endtask

  initial begin
    reset = 1'b1; vsync = 1'b0; de_pix = 1'b0; de_hog = 1'b0;
    alarms = 4'b0000; clr_sticky = 1'b0;
    test_reset();
    test_good_frame();
    test_short_frame();
    test_long_frame();
    test_alarm_and_sticky();
    test_features();
    test_reset_in_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
